timer_arbiter: RTL

Round-robin controller that shares one `timer_input` counter instance among N requesters, each requesting a delay of a programmable number of ticks. It latches the winning requester's duration onto the timer's `FINAL_VALUE`, gates the timer's `en` with a prescaler tick, watches `done`, and returns a one-cycle acknowledge to the requester. It sits between client FSMs that need timed waits and the single shared timer.

---
 rtl/timer_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one timer_input counter among N requesters.
// Latches the winner's duration onto the timer, gates en with tick, and acks on done.
module timer_arbiter #(
    parameter int N    = 4,
    parameter int BITS = 4,
    parameter int IDW  = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [N-1:0]      req,
    input  logic [N*BITS-1:0] dur,
    output logic [N-1:0]      ack,
    output logic              busy,
    output logic [IDW-1:0]    grant_id,
    output logic              tmr_en,
    output logic [BITS-1:0]   tmr_final,
    input  logic              tmr_done
);

    typedef enum logic [1:0] {IDLE, RUN, ACK} state_t;

    state_t            state, state_next;
    logic [IDW-1:0]    last, last_next;
    logic [IDW-1:0]    grant_next;
    logic [IDW-1:0]    winner;
    logic [IDW-1:0]    cand;
    logic              found;
    logic [BITS-1:0]   winner_dur;
    logic [BITS-1:0]   final_next;
    logic [N-1:0]      ack_next;
    logic              busy_next;

    // Search starts just after the last completed grant and wraps around.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDW'((int'(last) + k) % N);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        winner_dur = '0;
        for (int i = 0; i < N; i++) begin
            if (IDW'(i) == winner) begin
                winner_dur = dur[i*BITS +: BITS];
            end
        end
    end

    always_comb begin
        state_next = state;
        ack_next   = '0;
        grant_next = grant_id;
        final_next = tmr_final;
        last_next  = last;
        tmr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_next = winner;
                    final_next = winner_dur;
                    state_next = RUN;
                end
            end
            RUN: begin
                // done without tick is ignored: the timer only wraps on an enabled edge.
                tmr_en = tick;
                if (tick && tmr_done) begin
                    state_next         = ACK;
                    ack_next[grant_id] = 1'b1;
                    last_next          = grant_id;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ack       <= '0;
            busy      <= 1'b0;
            grant_id  <= '0;
            tmr_final <= '0;
            last      <= IDW'(N - 1);
        end else begin
            state     <= state_next;
            ack       <= ack_next;
            busy      <= busy_next;
            grant_id  <= grant_next;
            tmr_final <= final_next;
            last      <= last_next;
        end
    end

endmodule
